// File: rtl/test11_method_driver.sv
// test11_method_driver: single-outstanding, timeout-protected initiator for the Test11 add/sum/tst methods
module test11_method_driver #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_z,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_op,
  output logic [31:0]      resp_sum,
  output logic             resp_cry,
  output logic [1:0]       resp_tst,
  output logic             resp_timeout,
  input  logic             RDY_add,
  output logic             EN_add,
  output logic [31:0]      add_s_a,
  output logic [31:0]      add_s_b,
  input  logic             RDY_sum,
  input  logic [31:0]      sum_sum,
  input  logic             sum_cry,
  input  logic             RDY_tst,
  input  logic [1:0]       tst,
  output logic [2:0]       tst_z,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PROBE, RESP} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic active, done, expired;
  assign req_ready = state == IDLE && !RST;
  assign EN_add = state == ISSUE && RDY_add && !RST;
  assign resp_valid = state == RESP;
  assign busy = state != IDLE;
  // Completion wins over timeout; a timeout only fires in a busy state whose completion is absent
  always_comb begin
    active = state == ISSUE || state == WAIT || state == PROBE;
    done = (state == ISSUE && RDY_add) || (state == WAIT && RDY_sum) || (state == PROBE && RDY_tst);
    expired = active && !done && timer == TW'(TIMEOUT);
    state_n = state;
    case (state)
      IDLE:        state_n = req_valid ? (req_op ? PROBE : ISSUE) : IDLE;
      ISSUE:       state_n = RDY_add ? WAIT : (expired ? RESP : ISSUE);
      WAIT, PROBE: state_n = (done || expired) ? RESP : state;
      RESP:        state_n = resp_ready ? IDLE : RESP;
      default:     state_n = IDLE;
    endcase
  end
  // State register, request latches, saturating timer, response capture and handshake counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
      resp_op <= 1'b0;
      add_s_a <= '0;
      add_s_b <= '0;
      tst_z <= '0;
      resp_sum <= '0;
      resp_cry <= 1'b0;
      resp_tst <= '0;
      resp_timeout <= 1'b0;
      txn_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        resp_op <= req_op;
        add_s_a <= req_a;
        add_s_b <= req_b;
        tst_z <= req_z;
        timer <= '0;
      end else if (active && timer != TW'(TIMEOUT)) begin
        timer <= timer + TW'(1);
      end
      if (state == WAIT && RDY_sum) begin
        resp_sum <= sum_sum;
        resp_cry <= sum_cry;
        resp_tst <= '0;
        resp_timeout <= 1'b0;
      end else if (state == PROBE && RDY_tst) begin
        resp_sum <= '0;
        resp_cry <= 1'b0;
        resp_tst <= tst;
        resp_timeout <= 1'b0;
      end else if (expired) begin
        resp_sum <= '0;
        resp_cry <= 1'b0;
        resp_tst <= '0;
        resp_timeout <= 1'b1;
      end
      if (resp_valid && resp_ready) txn_count <= txn_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_test11_method_driver.sv
// tb_test11_method_driver: directed transactions against a timeline model derived from the handshake/timeout rules
module tb_test11_method_driver;
  localparam int T0 = 255;
  localparam int T1 = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic req_valid = 0, req_op = 0, resp_ready = 0, rdy_add = 0, rdy_sum = 0, sum_cry = 0, rdy_tst = 0;
  logic [31:0] req_a = 0, req_b = 0, sum_sum = 0;
  logic [2:0] req_z = 0;
  logic [1:0] tst = 0;
  logic req_ready_o[2], resp_valid_o[2], resp_op_o[2], resp_cry_o[2], resp_timeout_o[2], en_add_o[2], busy_o[2];
  logic [31:0] resp_sum_o[2], add_a_o[2], add_b_o[2];
  logic [1:0] resp_tst_o[2];
  logic [2:0] tst_z_o[2];
  logic [15:0] cnt_o[2];
  int s = 0;
  for (genvar i = 0; i < 2; i++) begin : g_dut
    test11_method_driver #(.TIMEOUT(i == 1 ? T1 : T0), .CNT_W(16)) dut (
      .CLK(clk), .RST(rst),
      .req_valid(req_valid && s == i), .req_ready(req_ready_o[i]), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_z(req_z),
      .resp_valid(resp_valid_o[i]), .resp_ready(resp_ready), .resp_op(resp_op_o[i]),
      .resp_sum(resp_sum_o[i]), .resp_cry(resp_cry_o[i]), .resp_tst(resp_tst_o[i]),
      .resp_timeout(resp_timeout_o[i]),
      .RDY_add(rdy_add), .EN_add(en_add_o[i]), .add_s_a(add_a_o[i]), .add_s_b(add_b_o[i]),
      .RDY_sum(rdy_sum), .sum_sum(sum_sum), .sum_cry(sum_cry),
      .RDY_tst(rdy_tst), .tst(tst), .tst_z(tst_z_o[i]),
      .busy(busy_o[i]), .txn_count(cnt_o[i])
    );
  end
  int pass_n = 0, total_n = 0, cyc = 0, en_first = -1, rv_first = -1;
  logic chk_on = 0, e_rr = 0, e_rv = 0, e_en = 0, e_busy = 0, e_cs = 0, e_ct = 0, e_op = 0, e_cry = 0, e_to = 0;
  logic [31:0] e_a = 0, e_b = 0, e_sum = 0, rv_sum = 0;
  logic [2:0] e_z = 0;
  logic [1:0] e_tst = 0, rv_tst = 0;
  logic [15:0] e_cnt = 0;
  logic rv_to = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", n, cyc, act, exp);
  endtask
  // Per-cycle comparison of the selected DUT against the timeline expectations
  always @(negedge clk) if (chk_on) begin
    chk("req_ready", req_ready_o[s], e_rr);
    chk("busy", busy_o[s], e_busy);
    chk("resp_valid", resp_valid_o[s], e_rv);
    chk("EN_add", en_add_o[s], e_en);
    chk("add_s_a", add_a_o[s], e_a);
    chk("add_s_b", add_b_o[s], e_b);
    chk("tst_z", tst_z_o[s], e_z);
    chk("txn_count", cnt_o[s], e_cnt);
    if (e_rv) begin
      chk("resp_op", resp_op_o[s], e_op);
      chk("resp_timeout", resp_timeout_o[s], e_to);
      if (e_cs) begin
        chk("resp_sum", resp_sum_o[s], e_sum);
        chk("resp_cry", resp_cry_o[s], e_cry);
      end
      if (e_ct) chk("resp_tst", resp_tst_o[s], e_tst);
    end
    if (en_add_o[s] && en_first < 0) en_first = cyc;
    if (resp_valid_o[s] && rv_first < 0) begin
      rv_first = cyc;
      rv_sum = resp_sum_o[s];
      rv_tst = resp_tst_o[s];
      rv_to = resp_timeout_o[s];
    end
  end
  // One transaction; ra/rs/rt are the cycles (after accept) from which RDY_add/RDY_sum/RDY_tst stay high
  task automatic xact(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] z,
                      input int ra, input int rs, input int rt, input logic [31:0] sv, input logic cv,
                      input logic [1:0] tv, input int hold);
    int t, f, e, w, lim, h;
    logic to;
    t = s ? T1 : T0;
    if (!op) begin
      f = ra < 1 ? 1 : ra;
      if (f > t + 1) begin
        f = -1; e = t + 1; to = 1;
      end else begin
        lim = f + 1 > t + 1 ? f + 1 : t + 1;
        w = rs > f + 1 ? rs : f + 1;
        to = w > lim;
        e = to ? lim : w;
      end
    end else begin
      f = -1;
      w = rt < 1 ? 1 : rt;
      to = w > t + 1;
      e = to ? t + 1 : w;
    end
    h = e + 1 + hold;
    sum_sum = sv; sum_cry = cv; tst = tv; req_op = op; req_a = a; req_b = b; req_z = z;
    en_first = -1; rv_first = -1;
    for (int c = 0; c <= h; c++) begin
      cyc = c;
      req_valid = c == 0; rdy_add = c >= ra; rdy_sum = c >= rs; rdy_tst = c >= rt; resp_ready = c >= h;
      e_rr = c == 0; e_busy = c > 0; e_rv = c > e; e_en = c == f;
      if (c == 1) begin e_a = a; e_b = b; e_z = z; end
      e_op = op; e_to = to; e_cs = !op || to; e_ct = op || to;
      e_sum = to ? 0 : sv; e_cry = to ? 0 : cv; e_tst = to ? 0 : tv;
      chk_on = 1;
      @(posedge clk); #1;
    end
    e_cnt++;
    req_valid = 0; resp_ready = 0; rdy_add = 0; rdy_sum = 0; rdy_tst = 0;
  endtask
  // Accept an add with RDY_sum held low, then pulse reset in cycle `at`
  task automatic rst_mid(input int at);
    req_op = 0; req_a = 32'hA5A5_0001; req_b = 32'h0F0F_0002; req_z = 3'b011;
    rdy_add = 1; rdy_sum = 0; rdy_tst = 0; resp_ready = 1; e_rv = 0; chk_on = 1;
    for (int c = 0; c <= at + 1; c++) begin
      cyc = c; req_valid = c == 0; rst = c == at;
      e_rr = c == 0 || c == at + 1; e_busy = c > 0 && c <= at; e_en = c == 1 && at != 1;
      if (c == 1) begin e_a = req_a; e_b = req_b; e_z = req_z; end
      if (c == at + 1) begin e_a = 0; e_b = 0; e_z = 0; end
      @(posedge clk); #1;
    end
    req_valid = 0; rdy_add = 0; resp_ready = 0;
  endtask
  initial begin
    rst = 1; req_valid = 1;
    @(posedge clk); #1;
    e_rr = 0; e_busy = 0; e_rv = 0; e_en = 0; e_cnt = 0; cyc = 0; chk_on = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_resp_sum", resp_sum_o[i], 0);
      chk("rst_resp_flags", {resp_op_o[i], resp_cry_o[i], resp_tst_o[i], resp_timeout_o[i]}, 0);
    end
    rst = 0; req_valid = 0; e_rr = 1;
    @(posedge clk); #1;
    rst_mid(1);
    rst_mid(2);
    xact(0, 32'd5, 32'd3, 3'b000, 0, 0, 1000, 32'd8, 0, 2'b00, 0);
    chk("lit_basic_en_cycle", en_first, 1);
    chk("lit_basic_rv_cycle", rv_first, 3);
    chk("lit_basic_sum", rv_sum, 8);
    chk("lit_basic_count", cnt_o[0], 1);
    xact(0, 32'hFFFF_FFFF, 32'd1, 3'b001, 11, 0, 1000, 32'd0, 1, 2'b00, 0);
    chk("lit_bp_en_cycle", en_first, 11);
    chk("lit_bp_latency", rv_first - en_first, 2);
    xact(1, 32'd0, 32'd0, 3'b101, 0, 0, 4, 32'h1234, 0, 2'b10, 0);
    chk("lit_probe_rv_cycle", rv_first, 5);
    chk("lit_probe_tst", rv_tst, 2'b10);
    xact(0, 32'd100, 32'd23, 3'b010, 0, 0, 1000, 32'd123, 0, 2'b00, 5);
    xact(0, 32'h8000_0000, 32'h8000_0000, 3'b110, 0, 0, 1000, 32'd0, 1, 2'b11, 0);
    s = 1; e_cnt = 0; e_a = 0; e_b = 0; e_z = 0;
    xact(0, 32'd7, 32'd9, 3'b100, 0, 1000, 1000, 32'hDEAD_BEEF, 1, 2'b11, 2);
    chk("lit_to_rv_cycle", rv_first, 10);
    chk("lit_to_flag", rv_to, 1);
    chk("lit_to_sum", rv_sum, 0);
    chk("lit_to_count", cnt_o[1], 1);
    xact(0, 32'd1, 32'd2, 3'b001, 1000, 0, 1000, 32'hCAFE_0000, 1, 2'b01, 0);
    xact(0, 32'd3, 32'd4, 3'b010, 0, 9, 1000, 32'h0000_0007, 0, 2'b00, 0);
    xact(0, 32'd5, 32'd6, 3'b011, 9, 0, 1000, 32'h0000_000B, 1, 2'b00, 1);
    xact(1, 32'd0, 32'd0, 3'b111, 0, 0, 1000, 32'hFFFF_FFFF, 1, 2'b11, 0);
    xact(1, 32'd0, 32'd0, 3'b010, 0, 0, 9, 32'd0, 0, 2'b01, 0);
    e_rr = 1; e_busy = 0; e_rv = 0; e_en = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk_on = 0;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
